adc_echo_train_seq: RTL and testbench

Echo-train scheduler for the ADC acquisition path. On a start command, it emits a train of NUM_ECHOES acquisition-window pulses (ACQ_WND) with a fixed rise-to-rise period. Each pulse feeds the ADC acquisition window generator, and the scheduler handshakes on that generator's idle/done flag so windows never retrigger a busy generator. It sits between the pulse-sequence control registers and the window generator, and reports train progress and overrun.

---
 rtl/adc_echo_train_seq.sv | 157 +++++++++++++++
 tb/tb_adc_echo_train_seq.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_echo_train_seq.sv
// Echo-train scheduler: emits NUM_ECHOES ACQ_WND pulses at a fixed period.
// Optional ABORT input enabled by defining ECHO_SEQ_ABORT_EN.
module adc_echo_train_seq #(
  parameter int CNT_WIDTH  = 32,
  parameter int ECHO_WIDTH = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic [ECHO_WIDTH-1:0] NUM_ECHOES,
  input  logic [CNT_WIDTH-1:0]  ECHO_PERIOD,
  input  logic [CNT_WIDTH-1:0]  WND_LEN,
  input  logic                  WINGEN_DONE,
`ifdef ECHO_SEQ_ABORT_EN
  input  logic                  ABORT,
`endif
  output logic                  ACQ_WND,
  output logic [ECHO_WIDTH-1:0] ECHO_IDX,
  output logic                  BUSY,
  output logic                  TRAIN_DONE,
  output logic                  OVERRUN
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WND,
    S_GAP,
    S_FINISH
  } state_t;

  localparam logic [CNT_WIDTH-1:0] C_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] C_TWO = CNT_WIDTH'(2);
  localparam logic [ECHO_WIDTH-1:0] E_ONE = ECHO_WIDTH'(1);

  state_t                 state;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [CNT_WIDTH-1:0]   per_r;
  logic [CNT_WIDTH-1:0]   wlen_r;
  logic [ECHO_WIDTH-1:0]  num_r;

  logic [CNT_WIDTH-1:0]   per_eff;
  logic [CNT_WIDTH-1:0]   wlen_min1;
  logic [CNT_WIDTH-1:0]   wlen_eff;
  logic                   abort_hit;
  logic                   last_echo;
  logic                   per_end;
  logic                   wnd_end;

  // Window length is kept strictly inside the period so GAP is never empty.
  always_comb begin
    per_eff   = (ECHO_PERIOD < C_TWO) ? C_TWO : ECHO_PERIOD;
    wlen_min1 = (WND_LEN == '0) ? C_ONE : WND_LEN;
    wlen_eff  = (wlen_min1 > per_eff - C_ONE) ? per_eff - C_ONE : wlen_min1;
  end

`ifdef ECHO_SEQ_ABORT_EN
  assign abort_hit = ABORT;
`else
  assign abort_hit = 1'b0;
`endif

  assign last_echo = (ECHO_IDX == num_r - E_ONE);
  assign per_end   = (cnt >= per_r);
  assign wnd_end   = (cnt >= wlen_r);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= S_IDLE;
      cnt        <= '0;
      per_r      <= '0;
      wlen_r     <= '0;
      num_r      <= '0;
      ACQ_WND    <= 1'b0;
      ECHO_IDX   <= '0;
      BUSY       <= 1'b0;
      TRAIN_DONE <= 1'b0;
      OVERRUN    <= 1'b0;
    end else begin
      TRAIN_DONE <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (START) begin
            if (NUM_ECHOES != '0) begin
              per_r    <= per_eff;
              wlen_r   <= wlen_eff;
              num_r    <= NUM_ECHOES;
              ECHO_IDX <= '0;
              OVERRUN  <= 1'b0;
              BUSY     <= 1'b1;
              cnt      <= '0;
              state    <= S_ARM;
            end else begin
              TRAIN_DONE <= 1'b1;
            end
          end
        end
        S_ARM: begin
          if (abort_hit) begin
            ACQ_WND <= 1'b0;
            state   <= S_FINISH;
          end else if (WINGEN_DONE) begin
            ACQ_WND <= 1'b1;
            cnt     <= C_ONE;
            state   <= S_WND;
          end
        end
        S_WND: begin
          if (abort_hit) begin
            ACQ_WND <= 1'b0;
            state   <= S_FINISH;
          end else begin
            cnt <= cnt + C_ONE;
            if (wnd_end) begin
              ACQ_WND <= 1'b0;
              state   <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (abort_hit) begin
            ACQ_WND <= 1'b0;
            state   <= S_FINISH;
          end else if (per_end) begin
            if (last_echo) begin
              state <= S_FINISH;
            end else begin
              ECHO_IDX <= ECHO_IDX + E_ONE;
              if (WINGEN_DONE) begin
                ACQ_WND <= 1'b1;
                cnt     <= C_ONE;
                state   <= S_WND;
              end else begin
                OVERRUN <= 1'b1;
                state   <= S_ARM;
              end
            end
          end else begin
            cnt <= cnt + C_ONE;
          end
        end
        S_FINISH: begin
          if (WINGEN_DONE) begin
            TRAIN_DONE <= 1'b1;
            BUSY       <= 1'b0;
            cnt        <= '0;
            state      <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_echo_train_seq.sv
// Scoreboard bench for adc_echo_train_seq: expected window rises queued
// by each scenario task, popped and checked by a negedge monitor.
module tb_adc_echo_train_seq;
  localparam int CW = 32;
  localparam int EW = 16;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          START;
  logic [EW-1:0] NUM_ECHOES;
  logic [CW-1:0] ECHO_PERIOD;
  logic [CW-1:0] WND_LEN;
  logic          WINGEN_DONE;
  logic          ABORT;
  logic          ACQ_WND;
  logic [EW-1:0] ECHO_IDX;
  logic          BUSY;
  logic          TRAIN_DONE;
  logic          OVERRUN;

  adc_echo_train_seq #(.CNT_WIDTH(CW), .ECHO_WIDTH(EW)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .START(START),
    .NUM_ECHOES(NUM_ECHOES),
    .ECHO_PERIOD(ECHO_PERIOD),
    .WND_LEN(WND_LEN),
    .WINGEN_DONE(WINGEN_DONE),
`ifdef ECHO_SEQ_ABORT_EN
    .ABORT(ABORT),
`endif
    .ACQ_WND(ACQ_WND),
    .ECHO_IDX(ECHO_IDX),
    .BUSY(BUSY),
    .TRAIN_DONE(TRAIN_DONE),
    .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  typedef struct {
    int rise;
    int len;
    int idx;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   passed = 0;
  int   total = 0;
  logic prev_acq = 1'b0;
  int   rise_c = 0;
  int   cur_len = 0;
  bit   len_chk = 0;
  int   td_cnt = 0;

  always @(negedge CLK) begin
    if (TRAIN_DONE === 1'b1) td_cnt++;
    if (ACQ_WND === 1'b1 && prev_acq === 1'b0) begin
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_rise cyc=%0d idx=%0d", cyc, ECHO_IDX);
      end else begin
        mon_e = exp_q.pop_front();
        if (cyc !== mon_e.rise || int'(ECHO_IDX) !== mon_e.idx)
          $display("FAIL rise got cyc=%0d idx=%0d want cyc=%0d idx=%0d",
                   cyc, ECHO_IDX, mon_e.rise, mon_e.idx);
        else passed++;
        cur_len = mon_e.len;
        len_chk = 1;
        rise_c  = cyc;
      end
    end
    if (ACQ_WND === 1'b0 && prev_acq === 1'b1 && len_chk) begin
      total++;
      if (cyc - rise_c !== cur_len)
        $display("FAIL wnd_len got %0d want %0d", cyc - rise_c, cur_len);
      else passed++;
      len_chk = 0;
    end
    prev_acq = ACQ_WND;
  end

  task automatic push(input int r, input int l, input int i);
    exp_t e;
    e.rise = r;
    e.len  = l;
    e.idx  = i;
    exp_q.push_back(e);
  endtask

  // Returns t = edge count at which START was sampled; config then scrambled.
  task automatic start_train(input int n, input int p, input int w,
                             output int t);
    @(negedge CLK);
    NUM_ECHOES  = EW'(n);
    ECHO_PERIOD = CW'(p);
    WND_LEN     = CW'(w);
    START       = 1'b1;
    @(negedge CLK);
    START       = 1'b0;
    t           = cyc;
    NUM_ECHOES  = EW'(7);
    ECHO_PERIOD = CW'(3);
    WND_LEN     = CW'(1);
  endtask

  task automatic wait_done(input int bound, output int tc);
    tc = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge CLK);
      if (TRAIN_DONE === 1'b1) begin
        tc = cyc;
        break;
      end
    end
    total++;
    if (tc < 0) $display("FAIL train_done_timeout got none want pulse");
    else passed++;
  endtask

  task automatic test_reset();
    RESET = 1'b1; START = 1'b0; WINGEN_DONE = 1'b1; ABORT = 1'b0;
    NUM_ECHOES = '0; ECHO_PERIOD = '0; WND_LEN = '0;
    repeat (3) @(negedge CLK);
    total++;
    if ({ACQ_WND, ECHO_IDX, BUSY, TRAIN_DONE, OVERRUN} !== '0)
      $display("FAIL reset_outputs got %b want 0",
               {ACQ_WND, ECHO_IDX, BUSY, TRAIN_DONE, OVERRUN});
    else passed++;
    RESET = 1'b0;
  endtask

  task automatic test_basic();
    int t, tc, td0;
    td0 = td_cnt;
    start_train(3, 10, 4, t);
    total++;
    if (BUSY !== 1'b1 || ACQ_WND !== 1'b0)
      $display("FAIL basic_latency got busy=%b acq=%b want 1 0", BUSY, ACQ_WND);
    else passed++;
    push(t + 1, 4, 0); push(t + 11, 4, 1); push(t + 21, 4, 2);
    wait_done(100, tc);
    total++;
    if (tc !== t + 32 || BUSY !== 1'b0)
      $display("FAIL basic_done got cyc=%0d busy=%b want %0d 0", tc, BUSY, t + 32);
    else passed++;
    @(negedge CLK);
    total++;
    if (TRAIN_DONE !== 1'b0 || td_cnt - td0 !== 1 || exp_q.size() != 0)
      $display("FAIL basic_pulse got td=%b n=%0d left=%0d want 0 1 0",
               TRAIN_DONE, td_cnt - td0, exp_q.size());
    else passed++;
    total++;
    if (OVERRUN !== 1'b0 || ECHO_IDX !== EW'(2))
      $display("FAIL basic_status got ovr=%b idx=%0d want 0 2", OVERRUN, ECHO_IDX);
    else passed++;
  endtask

  task automatic test_overrun();
    int t, tc;
    start_train(3, 10, 4, t);
    push(t + 1, 4, 0); push(t + 16, 4, 1); push(t + 26, 4, 2);
    while (cyc < t + 10) @(negedge CLK);
    WINGEN_DONE = 1'b0;
    while (cyc < t + 15) @(negedge CLK);
    total++;
    if (OVERRUN !== 1'b1 || ACQ_WND !== 1'b0 || BUSY !== 1'b1)
      $display("FAIL overrun_stall got ovr=%b acq=%b busy=%b want 1 0 1",
               OVERRUN, ACQ_WND, BUSY);
    else passed++;
    WINGEN_DONE = 1'b1;
    wait_done(100, tc);
    total++;
    if (tc !== t + 37 || OVERRUN !== 1'b1 || exp_q.size() != 0)
      $display("FAIL overrun_done got cyc=%0d ovr=%b left=%0d want %0d 1 0",
               tc, OVERRUN, exp_q.size(), t + 37);
    else passed++;
  endtask

  task automatic test_clamp();
    int t, tc;
    start_train(3, 1, 0, t);
    total++;
    if (OVERRUN !== 1'b0)
      $display("FAIL overrun_clear got %b want 0", OVERRUN);
    else passed++;
    push(t + 1, 1, 0); push(t + 3, 1, 1); push(t + 5, 1, 2);
    wait_done(50, tc);
    total++;
    if (tc !== t + 8 || exp_q.size() != 0)
      $display("FAIL clamp_done got cyc=%0d left=%0d want %0d 0",
               tc, exp_q.size(), t + 8);
    else passed++;
  endtask

  task automatic test_empty();
    int t, td0;
    bit bad;
    @(negedge CLK);
    td0 = td_cnt;
    start_train(0, 10, 4, t);
    total++;
    if (TRAIN_DONE !== 1'b1 || BUSY !== 1'b0)
      $display("FAIL empty_done got td=%b busy=%b want 1 0", TRAIN_DONE, BUSY);
    else passed++;
    bad = 0;
    repeat (10) begin
      @(negedge CLK);
      if (BUSY !== 1'b0 || ACQ_WND !== 1'b0 || TRAIN_DONE !== 1'b0) bad = 1;
    end
    total++;
    if (bad || td_cnt - td0 !== 1)
      $display("FAIL empty_quiet got bad=%0d pulses=%0d want 0 1",
               bad, td_cnt - td0);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int t, t2, tc;
    start_train(3, 10, 4, t);
    push(t + 1, 4, 0); push(t + 11, 4, 1);
    while (cyc < t + 12) @(negedge CLK);
    total++;
    if (ACQ_WND !== 1'b1 || ECHO_IDX !== EW'(1))
      $display("FAIL mid_pre got acq=%b idx=%0d want 1 1", ACQ_WND, ECHO_IDX);
    else passed++;
    RESET = 1'b1;
    exp_q.delete();
    len_chk = 0;
    @(negedge CLK);
    total++;
    if ({ACQ_WND, ECHO_IDX, BUSY, TRAIN_DONE, OVERRUN} !== '0)
      $display("FAIL mid_reset got %b want 0",
               {ACQ_WND, ECHO_IDX, BUSY, TRAIN_DONE, OVERRUN});
    else passed++;
    RESET = 1'b0;
    start_train(2, 6, 2, t2);
    total++;
    if (ECHO_IDX !== '0 || BUSY !== 1'b1)
      $display("FAIL fresh_start got idx=%0d busy=%b want 0 1", ECHO_IDX, BUSY);
    else passed++;
    push(t2 + 1, 2, 0); push(t2 + 7, 2, 1);
    wait_done(100, tc);
    total++;
    if (tc !== t2 + 14 || ECHO_IDX !== EW'(1) || exp_q.size() != 0)
      $display("FAIL fresh_done got cyc=%0d idx=%0d left=%0d want %0d 1 0",
               tc, ECHO_IDX, exp_q.size(), t2 + 14);
    else passed++;
  endtask

`ifdef ECHO_SEQ_ABORT_EN
  task automatic test_abort();
    int t, tc;
    start_train(4, 10, 4, t);
    push(t + 1, 4, 0); push(t + 11, 4, 1);
    while (cyc < t + 16) @(negedge CLK);
    ABORT = 1'b1;
    WINGEN_DONE = 1'b0;
    @(negedge CLK);
    ABORT = 1'b0;
    repeat (3) @(negedge CLK);
    total++;
    if (BUSY !== 1'b1 || TRAIN_DONE !== 1'b0 || ACQ_WND !== 1'b0)
      $display("FAIL abort_wait got busy=%b td=%b acq=%b want 1 0 0",
               BUSY, TRAIN_DONE, ACQ_WND);
    else passed++;
    WINGEN_DONE = 1'b1;
    wait_done(50, tc);
    total++;
    if (tc !== t + 21 || ECHO_IDX !== EW'(1))
      $display("FAIL abort_done got cyc=%0d idx=%0d want %0d 1",
               tc, ECHO_IDX, t + 21);
    else passed++;
    repeat (30) @(negedge CLK);
    total++;
    if (exp_q.size() != 0 || BUSY !== 1'b0)
      $display("FAIL abort_quiet got left=%0d busy=%b want 0 0",
               exp_q.size(), BUSY);
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_clamp();
    test_empty();
    test_reset_mid();
`ifdef ECHO_SEQ_ABORT_EN
    test_abort();
`endif
    repeat (5) @(negedge CLK);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
